// File: rtl/obuf_drain_if.sv
// obuf_drain_if: downstream valid/ready stream carrying requantized elements.
//   data  - requantized signed element (OUT_WIDTH bits)
//   valid - data is valid
//   ready - downstream accepts; transfer when valid && ready
//   last  - marks the final element of a drain
// master modport: producer (obuf_drain). slave modport: consumer.
interface obuf_drain_if #(
    parameter int OUT_WIDTH = 8
);
    logic [OUT_WIDTH-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/obuf_drain.sv
// obuf_drain: read-side controller for the output accumulation buffer.
// On start it walks buffer addresses 0..DEPTH-1 over a registered read port
// (one-cycle latency), requantizes each WIDTH-bit signed partial sum to
// OUT_WIDTH bits (optional ReLU, arithmetic shift right by SHIFT, saturate)
// and streams the results on a valid/ready interface.
//
// Build option: define OBUF_DRAIN_RELU_EN to clamp negative accumulators
// to zero before shifting.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous reset, active low
//   start_i  - one-cycle drain request, ignored while busy_o
//   busy_o   - drain in progress
//   done_o   - one-cycle pulse after the last output handshake
//   raddr_o  - buffer read address (data returns next cycle)
//   rdata_i  - buffer read data for last cycle's raddr_o
//   out_if   - downstream element stream (master)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i; no reads issued
// DRAIN | issuing reads and streaming elements until last handshake
module obuf_drain #(
    parameter int WIDTH     = 19,
    parameter int DEPTH     = 8,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH)-1:0] raddr_o,
    input  logic [WIDTH-1:0]         rdata_i,
    obuf_drain_if.master             out_if
);
    localparam int AW        = $clog2(DEPTH);
    localparam int SAT_MAX_I = (1 << (OUT_WIDTH - 1)) - 1;
    localparam logic signed [WIDTH-1:0] SAT_MAX = WIDTH'(SAT_MAX_I);
    localparam logic signed [WIDTH-1:0] SAT_MIN = WIDTH'(-SAT_MAX_I - 1);

    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

    state_t               state_q;
    logic [AW:0]          iss_q;
    logic                 rv_q;
    logic [AW-1:0]        pa_q;
    logic [OUT_WIDTH-1:0] data_q;
    logic                 valid_q;
    logic                 last_q;
    logic                 busy_q;
    logic                 done_q;

    logic consume;
    logic issue;
    logic xfer;

    function automatic logic [OUT_WIDTH-1:0] requant(input logic [WIDTH-1:0] raw);
        logic signed [WIDTH-1:0] v;
        v = signed'(raw);
`ifdef OBUF_DRAIN_RELU_EN
        if (v < 0) v = '0;
`endif
        v = v >>> SHIFT;
        if (v > SAT_MAX) v = SAT_MAX;
        else if (v < SAT_MIN) v = SAT_MIN;
        return v[OUT_WIDTH-1:0];
    endfunction

    // The element sitting on rdata_i may move into the output register when
    // the register is empty or is being emptied this cycle.
    assign consume = rv_q && (!valid_q || out_if.ready);
    assign issue   = (state_q == ST_DRAIN) && (iss_q < (AW+1)'(DEPTH)) && (!rv_q || consume);
    assign xfer    = valid_q && out_if.ready;

    // When stalled, re-present the held element's address so the registered
    // read port keeps returning the same data.
    assign raddr_o = issue ? iss_q[AW-1:0] : pa_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            iss_q   <= '0;
            rv_q    <= 1'b0;
            pa_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (consume) begin
                data_q  <= requant(rdata_i);
                valid_q <= 1'b1;
                last_q  <= (pa_q == AW'(DEPTH - 1));
            end else if (xfer) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end

            if (issue) begin
                pa_q  <= iss_q[AW-1:0];
                rv_q  <= 1'b1;
                iss_q <= iss_q + 1'b1;
            end else if (consume) begin
                rv_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_DRAIN;
                        busy_q  <= 1'b1;
                        iss_q   <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (xfer && last_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign out_if.data  = data_q;
    assign out_if.valid = valid_q;
    assign out_if.last  = last_q;
endmodule

// File: tb/tb_obuf_drain.sv
// tb_obuf_drain: directed bench for obuf_drain with a registered-read buffer model.
module tb_obuf_drain;
    localparam int WIDTH = 19, DEPTH = 8, OUT_WIDTH = 8, SHIFT = 4, AW = 3;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy, done;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    obuf_drain_if #(.OUT_WIDTH(OUT_WIDTH)) ob_if ();

    obuf_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .raddr_o (raddr),
        .rdata_i (rdata),
        .out_if  (ob_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] e8(input int v);
        logic [7:0] t;
        t = v[7:0];
        return {24'b0, t};
    endfunction

    // Leaves the bench at the sample point of cycle 1 (start sampled at edge 0).
    task automatic start_drain();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < DEPTH; k++) mem[k] = WIDTH'(16 * k);
    endtask

    initial begin
        int exp_q [4];
        int got, ndone, c;
        logic r, stalled_prev, done_seen;
        logic [7:0] pdata;
        logic [1:0] pat [4];

        fill_ramp();
        ob_if.ready = 1'b1;

        // reset state
        tick(); tick();
        chk("rst_valid", ob_if.valid, 0);
        chk("rst_data", ob_if.data, 0);
        chk("rst_last", ob_if.last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_raddr", raddr, 0);
        rst_n = 1'b1;
        tick();

        // ramp drain, ready held high
        start_drain();
        chk("t1_busy_c1", busy, 1);
        chk("t1_raddr_c1", raddr, 0);
        chk("t1_valid_c1", ob_if.valid, 0);
        tick(); tick();
        for (int k = 0; k < DEPTH; k++) begin
            chk("t1_valid", ob_if.valid, 1);
            chk("t1_data", ob_if.data, e8(k));
            chk("t1_last", ob_if.last, (k == DEPTH - 1) ? 1 : 0);
            chk("t1_done_early", done, 0);
            tick();
        end
        chk("t1_done", done, 1);
        chk("t1_busy_fall", busy, 0);
        chk("t1_valid_end", ob_if.valid, 0);
        tick();
        chk("t1_done_pulse", done, 0);

        // requantization: saturate high, saturate low, floor on negative, plain shift
        mem[0] = WIDTH'(40000);
        mem[1] = WIDTH'(-3000);
        mem[2] = WIDTH'(-20);
        mem[3] = WIDTH'(255);
        for (int k = 4; k < DEPTH; k++) mem[k] = '0;
`ifdef OBUF_DRAIN_RELU_EN
        exp_q = '{127, 0, 0, 15};
`else
        exp_q = '{127, -128, -2, 15};
`endif
        start_drain();
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            chk("t2_valid", ob_if.valid, 1);
            chk("t2_data", ob_if.data, e8(exp_q[k]));
            tick();
        end
        for (int k = 4; k < DEPTH; k++) begin
            chk("t2_zero", ob_if.data, 0);
            tick();
        end
        chk("t2_done", done, 1);
        tick();

        // random backpressure beginning with 1,0,0,1
        fill_ramp();
        pat = '{2'd1, 2'd0, 2'd0, 2'd1};
        start_drain();
        got = 0;
        stalled_prev = 1'b0;
        done_seen = 1'b0;
        pdata = '0;
        c = 0;
        while (c < 300 && !done_seen) begin
            if (done) begin
                done_seen = 1'b1;
            end else begin
                r = (c < 4) ? pat[c][0] : 1'($urandom_range(0, 1));
                ob_if.ready = r;
                #1;
                if (stalled_prev) begin
                    chk("t3_stall_valid", ob_if.valid, 1);
                    chk("t3_stall_data", ob_if.data, {24'b0, pdata});
                end
                if (ob_if.valid && !r && got < DEPTH - 1)
                    chk("t3_raddr_hold", raddr, got + 1);
                if (ob_if.valid && r) begin
                    chk("t3_order", ob_if.data, e8(got));
                    chk("t3_last", ob_if.last, (got == DEPTH - 1) ? 1 : 0);
                    got++;
                end
                stalled_prev = ob_if.valid && !r;
                pdata = ob_if.data;
                tick();
            end
            c++;
        end
        chk("t3_done_seen", done_seen, 1);
        chk("t3_count", got, DEPTH);
        ob_if.ready = 1'b1;
        tick();

        // start pulses mid-drain are ignored
        start_drain();
        got = 0;
        ndone = 0;
        for (int cy = 1; cy <= 20; cy++) begin
            if (ob_if.valid) begin
                chk("t4_order", ob_if.data, e8(got));
                got++;
            end
            if (done) ndone++;
            start = (cy == 5 || cy == 6);
            tick();
        end
        start = 1'b0;
        chk("t4_count", got, DEPTH);
        chk("t4_ndone", ndone, 1);
        chk("t4_busy", busy, 0);

        // reset mid-drain, then restart
        start_drain();
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_valid", ob_if.valid, 0);
        chk("t5_data", ob_if.data, 0);
        chk("t5_last", ob_if.last, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_raddr", raddr, 0);
        tick();
        chk("t5_valid_held", ob_if.valid, 0);
        rst_n = 1'b1;
        tick();
        start_drain();
        chk("t5_re_raddr", raddr, 0);
        chk("t5_re_busy", busy, 1);
        tick(); tick();
        chk("t5_re_valid", ob_if.valid, 1);
        chk("t5_re_data0", ob_if.data, 0);
        ndone = 0;
        for (int cy = 0; cy < 20; cy++) begin
            if (done) ndone++;
            tick();
        end
        chk("t5_re_ndone", ndone, 1);

        // long stall on element 0, then back-to-back stream
        start_drain();
        tick(); tick();
        for (int i = 0; i < 20; i++) begin
            chk("t6_hold_valid", ob_if.valid, 1);
            chk("t6_hold_data", ob_if.data, 0);
            ob_if.ready = 1'b0;
            tick();
        end
        ob_if.ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk("t6_stream_valid", ob_if.valid, 1);
            chk("t6_stream_data", ob_if.data, e8(k));
            tick();
        end
        chk("t6_done", done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
